// File: rtl/xorwow_pkg.sv
// Shared types and constants for the xorwow stream reader.
// Optional zero-seed replacement is enabled by defining ZERO_SEED_GUARD_EN.
package xorwow_pkg;

  // Encoding is {p, l} as seen on the generator command pins.
  typedef enum logic [1:0] {
    CMD_GEN   = 2'b00,
    CMD_PAUSE = 2'b10,
    CMD_LOAD  = 2'b11
  } gen_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } reader_state_t;

  localparam int unsigned GEN_LATENCY = 2;

  localparam logic [31:0] SEED_DEF0 = 32'd123456789;
  localparam logic [31:0] SEED_DEF1 = 32'd362436069;
  localparam logic [31:0] SEED_DEF2 = 32'd521288629;
  localparam logic [31:0] SEED_DEF3 = 32'd88675123;
  localparam logic [31:0] SEED_DEF4 = 32'd5783321;

  localparam logic [31:0] COUNTER_INC = 32'd362437;

  function automatic logic cmd_p(gen_cmd_t c);
    return c[1];
  endfunction

  function automatic logic cmd_l(gen_cmd_t c);
    return c[0];
  endfunction

endpackage

// File: rtl/xorwow_stream_reader_fifo.sv
// Show-ahead synchronous FIFO with flush; head word read straight from storage.
module xorwow_sync_fifo
  import xorwow_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   din,
  input  logic          pop,
  output logic [31:0]   dout,
  output logic          valid,
  output logic [AW:0]   level
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= din;
  end

  assign dout  = mem[rd_q];
  assign valid = (cnt_q != '0);
  assign level = cnt_q;

endmodule

// File: rtl/xorwow_stream_reader.sv
// Drives an xorwow generator and buffers its words in a credit-controlled FIFO.
// Define ZERO_SEED_GUARD_EN to replace all-zero seeds and expose seed_fixed.
module xorwow_stream_reader
  import xorwow_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          seed_valid,
  output logic          seed_ready,
  input  logic [31:0]   seed_x0,
  input  logic [31:0]   seed_x1,
  input  logic [31:0]   seed_x2,
  input  logic [31:0]   seed_x3,
  input  logic [31:0]   seed_x4,
  output logic          gen_rst,
  output logic          gen_p,
  output logic          gen_l,
  output logic [31:0]   gen_x0,
  output logic [31:0]   gen_x1,
  output logic [31:0]   gen_x2,
  output logic [31:0]   gen_x3,
  output logic [31:0]   gen_x4,
  input  logic [31:0]   gen_out,
  output logic [31:0]   m_data,
  output logic          m_valid,
  input  logic          m_ready,
`ifdef ZERO_SEED_GUARD_EN
  output logic          seed_fixed,
`endif
  output logic [AW:0]   level
);

  localparam int IW = $clog2(GEN_LATENCY + 1);

  reader_state_t          state_q, state_d;
  gen_cmd_t               cmd;
  logic [GEN_LATENCY-1:0] fpipe_q;
  logic [IW-1:0]          inflight;
  logic [4:0][31:0]       gx_q, shadow_q, seed_in, seed_sel;
  logic                   gen_rst_q, seed_acc, can_gen, drain_done;
  logic                   push, pop, flush;
  logic [AW+1:0]          credit_need;

  assign seed_in = {seed_x4, seed_x3, seed_x2, seed_x1, seed_x0};

`ifdef ZERO_SEED_GUARD_EN
  logic seed_zero, seed_fixed_q;
  assign seed_zero = (seed_in == '0);
  assign seed_sel  = seed_zero ? {SEED_DEF4, SEED_DEF3, SEED_DEF2, SEED_DEF1, SEED_DEF0}
                               : seed_in;
  assign seed_fixed = seed_fixed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       seed_fixed_q <= 1'b0;
    else if (seed_acc && seed_zero) seed_fixed_q <= 1'b1;
  end
`else
  assign seed_sel = seed_in;
`endif

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < GEN_LATENCY; i++)
      inflight = inflight + IW'(fpipe_q[i]);
  end

  // A pop this cycle is not credited; the freed slot counts once level updates.
  assign credit_need = (AW+2)'(level) + (AW+2)'(inflight) + (AW+2)'(1);
  assign can_gen     = run && (credit_need <= (AW+2)'(DEPTH));

  assign seed_ready = gen_rst_q && (state_q == IDLE || state_q == RUN);
  assign seed_acc   = seed_valid && seed_ready;
  assign drain_done = (state_q == DRAIN) && (inflight == '0);

  always_comb begin
    state_d = state_q;
    cmd     = CMD_PAUSE;
    case (state_q)
      IDLE:  if (seed_acc) state_d = LOAD;
      LOAD: begin
        cmd     = CMD_LOAD;
        state_d = RUN;
      end
      RUN: begin
        if (seed_acc)     state_d = DRAIN;
        else if (can_gen) cmd     = CMD_GEN;
      end
      DRAIN: if (drain_done) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fpipe_q   <= '0;
      gen_rst_q <= 1'b0;
      gx_q      <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      fpipe_q   <= {fpipe_q[GEN_LATENCY-2:0], (cmd == CMD_GEN)};
      gen_rst_q <= 1'b1;
      if (state_q == IDLE && seed_acc) gx_q <= seed_sel;
      else if (drain_done)             gx_q <= shadow_q;
      if (state_q == RUN && seed_acc) shadow_q <= seed_sel;
    end
  end

  assign push  = fpipe_q[GEN_LATENCY-1];
  assign pop   = m_valid && m_ready;
  assign flush = (state_q == LOAD);

  xorwow_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (gen_out),
    .pop   (pop),
    .dout  (m_data),
    .valid (m_valid),
    .level (level)
  );

  assign gen_rst = gen_rst_q;
  assign gen_p   = cmd_p(cmd);
  assign gen_l   = cmd_l(cmd);
  assign gen_x0  = gx_q[0];
  assign gen_x1  = gx_q[1];
  assign gen_x2  = gx_q[2];
  assign gen_x3  = gx_q[3];
  assign gen_x4  = gx_q[4];

endmodule
